// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request port between the fetch controller and a
// variable-latency instruction memory.
interface fetch_ctrl_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
);
    logic                   IMemReq;
    logic [ADDR_WIDTH-1:0]  IMemAddr;
    logic                   IMemReady;
    logic [INSTR_WIDTH-1:0] IMemRData;

    modport master (
        output IMemReq,
        output IMemAddr,
        input  IMemReady,
        input  IMemRData
    );

    modport slave (
        input  IMemReq,
        input  IMemAddr,
        output IMemReady,
        output IMemRData
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: owns PCF, picks the next PC and runs the
// request/ready handshake with a variable-latency instruction memory.
module fetch_ctrl #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    INSTR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    MAX_WAIT     = 15
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [1:0]             PCSrcD,
    input  logic [ADDR_WIDTH-1:0]  PCBranchD,
    input  logic [ADDR_WIDTH-1:0]  PCJump,
    input  logic                   StallF,
    fetch_ctrl_if.master           imem,
    output logic [ADDR_WIDTH-1:0]  PCF,
    output logic [ADDR_WIDTH-1:0]  PCPlus4F,
    output logic [INSTR_WIDTH-1:0] InstrF,
    output logic                   InstrValidF,
    output logic                   FetchStallF,
    output logic                   FetchErr
);

    localparam int                CNT_W   = $clog2(MAX_WAIT + 2);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0]  CNT_SAT = CNT_W'(MAX_WAIT + 1);

    typedef enum logic [1:0] {S_BOOT, S_FETCH, S_WAIT} state_t;

    state_t                 state, state_nxt;
    logic [ADDR_WIDTH-1:0]  pc_nxt, seq_pc, redir_tgt;
    logic [ADDR_WIDTH-1:0]  pend_pc, pend_pc_nxt;
    logic [INSTR_WIDTH-1:0] instr_nxt;
    logic                   vld_nxt, pend, pend_nxt, err_nxt, redir_now;
    logic [CNT_W-1:0]       wait_cnt, wait_cnt_nxt;

    function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] a);
        return {a[ADDR_WIDTH-1:2], 2'b00};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c >= CNT_SAT) ? CNT_SAT : c + CNT_W'(1);
    endfunction

    assign PCPlus4F      = PCF + ADDR_WIDTH'(4);
    assign imem.IMemAddr = PCF;
    assign FetchStallF   = (state == S_WAIT);

    // PCSrcD=11 deliberately falls through to sequential fetch.
    always_comb begin
        redir_now = (PCSrcD == 2'b01) || (PCSrcD == 2'b10);
        redir_tgt = word_align((PCSrcD == 2'b01) ? PCBranchD : PCJump);
        seq_pc    = redir_now ? redir_tgt : PCPlus4F;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_BOOT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        imem.IMemReq = 1'b0;
        pc_nxt       = PCF;
        instr_nxt    = InstrF;
        vld_nxt      = InstrValidF;
        pend_nxt     = pend;
        pend_pc_nxt  = pend_pc;
        wait_cnt_nxt = wait_cnt;
        err_nxt      = FetchErr;
        case (state)
            S_BOOT: state_nxt = S_FETCH;
            S_FETCH: begin
                if (!StallF) begin
                    imem.IMemReq = 1'b1;
                    if (imem.IMemReady) begin
                        instr_nxt = imem.IMemRData;
                        vld_nxt   = 1'b1;
                        pc_nxt    = seq_pc;
                    end else begin
                        state_nxt    = S_WAIT;
                        vld_nxt      = 1'b0;
                        wait_cnt_nxt = '0;
                        pend_nxt     = 1'b0;
                    end
                end
            end
            S_WAIT: begin
                // The outstanding request must complete, so StallF is not consulted here.
                imem.IMemReq = 1'b1;
                wait_cnt_nxt = sat_inc(wait_cnt);
                if (wait_cnt == CNT_MAX) err_nxt = 1'b1;
                if (redir_now) begin
                    pend_nxt    = 1'b1;
                    pend_pc_nxt = redir_tgt;
                end
                if (imem.IMemReady) begin
                    state_nxt = S_FETCH;
                    pend_nxt  = 1'b0;
                    if (pend || redir_now) begin
                        // Word fetched on the wrong path: drop it and restart at the target.
                        vld_nxt = 1'b0;
                        pc_nxt  = redir_now ? redir_tgt : pend_pc;
                    end else begin
                        instr_nxt = imem.IMemRData;
                        vld_nxt   = 1'b1;
                        pc_nxt    = PCPlus4F;
                    end
                end
            end
            default: state_nxt = S_BOOT;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PCF         <= RESET_VECTOR;
            InstrF      <= '0;
            InstrValidF <= 1'b0;
            pend        <= 1'b0;
            pend_pc     <= '0;
            wait_cnt    <= '0;
            FetchErr    <= 1'b0;
        end else begin
            PCF         <= pc_nxt;
            InstrF      <= instr_nxt;
            InstrValidF <= vld_nxt;
            pend        <= pend_nxt;
            pend_pc     <= pend_pc_nxt;
            wait_cnt    <= wait_cnt_nxt;
            FetchErr    <= err_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: per-cycle vector table with a
// scoreboard of post-edge expectations, plus reset and timeout sequences.
module tb_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  PCSrcD = 2'b00;
    logic [31:0] PCBranchD = '0, PCJump = '0;
    logic        StallF = 1'b0;
    logic [31:0] PCF, PCPlus4F, InstrF;
    logic        InstrValidF, FetchStallF, FetchErr;

    int checks = 0;
    int errors = 0;

    fetch_ctrl_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) imem ();

    fetch_ctrl #(
        .ADDR_WIDTH(32), .INSTR_WIDTH(32), .RESET_VECTOR(32'h0), .MAX_WAIT(15)
    ) dut (
        .CLK(CLK), .RST(RST), .PCSrcD(PCSrcD), .PCBranchD(PCBranchD),
        .PCJump(PCJump), .StallF(StallF), .imem(imem), .PCF(PCF),
        .PCPlus4F(PCPlus4F), .InstrF(InstrF), .InstrValidF(InstrValidF),
        .FetchStallF(FetchStallF), .FetchErr(FetchErr)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  src;
        logic [31:0] br, jp;
        logic        stall, rdy;
        logic [31:0] rdata;
        logic        exp_req, exp_fs;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc, exp_instr;
        logic        exp_vld, exp_err;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Unselected target inputs carry distractor values so a wrong mux leg shows up.
    function automatic vec_t mk(input logic [1:0] src, input logic [31:0] tgt,
                                input logic stall, input logic rdy, input logic [31:0] rd,
                                input logic req, input logic fs, input logic [31:0] addr,
                                input logic [31:0] pc, input logic [31:0] ins,
                                input logic vld, input logic err);
        vec_t v;
        v.src = src;  v.stall = stall;  v.rdy = rdy;  v.rdata = rd;
        v.br  = (src == 2'b01) ? tgt : 32'h0000_0BA0;
        v.jp  = (src == 2'b10) ? tgt : 32'h0000_0CA0;
        v.exp_req = req;  v.exp_fs = fs;  v.exp_addr = addr;
        v.exp_pc = pc;  v.exp_instr = ins;  v.exp_vld = vld;  v.exp_err = err;
        return v;
    endfunction

    task automatic step(input vec_t v);
        vec_t e;
        @(negedge CLK);
        PCSrcD = v.src;  PCBranchD = v.br;  PCJump = v.jp;  StallF = v.stall;
        imem.IMemReady = v.rdy;  imem.IMemRData = v.rdata;
        #1;
        chk("imem_req",  imem.IMemReq, v.exp_req);
        chk("imem_addr", imem.IMemAddr, v.exp_addr);
        chk("pcf_pre",   PCF, v.exp_addr);
        chk("pcplus4",   PCPlus4F, v.exp_addr + 32'd4);
        chk("fetch_stall", FetchStallF, v.exp_fs);
        sb.push_back(v);
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
            e = sb.pop_front();
            chk("pcf",       PCF, e.exp_pc);
            chk("instrf",    InstrF, e.exp_instr);
            chk("instr_vld", InstrValidF, e.exp_vld);
            chk("fetch_err", FetchErr, e.exp_err);
        end
    endtask

    // nlow cycles with IMemReady low (first one in FETCH), then completion.
    task automatic run_wait(input int nlow, input logic [31:0] pc, input logic [31:0] old_ins,
                            input logic [31:0] new_ins, input logic err_after);
        step(mk(2'b00, 32'h0, 1'b0, 1'b0, 32'hDEAD_0000, 1'b1, 1'b0, pc, pc, old_ins, 1'b0, 1'b0));
        for (int i = 1; i < nlow; i++)
            step(mk(2'b00, 32'h0, 1'b0, 1'b0, 32'hDEAD_0000 + i, 1'b1, 1'b1, pc, pc, old_ins, 1'b0, 1'b0));
        step(mk(2'b00, 32'h0, 1'b0, 1'b1, new_ins, 1'b1, 1'b1, pc, pc + 32'd4, new_ins, 1'b1, err_after));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout at %0t", $time);
        $fatal(1, "bench time limit reached");
    end

    initial begin
        imem.IMemReady = 1'b0;
        imem.IMemRData = '0;

        //           src    tgt            stl  rdy  rdata         req  fs   addr           pc             instr         vld  err
        tbl.push_back(mk(2'b00, 32'h0,         1'b0, 1'b1, 32'hA000_0000, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0,         1'b0, 1'b0));
        tbl.push_back(mk(2'b00, 32'h0,         1'b0, 1'b1, 32'hA000_0001, 1'b1, 1'b0, 32'h0,         32'h4,         32'hA000_0001, 1'b1, 1'b0));
        tbl.push_back(mk(2'b00, 32'h0,         1'b0, 1'b1, 32'hA000_0002, 1'b1, 1'b0, 32'h4,         32'h8,         32'hA000_0002, 1'b1, 1'b0));
        tbl.push_back(mk(2'b00, 32'h0,         1'b0, 1'b0, 32'hBAD0_0003, 1'b1, 1'b0, 32'h8,         32'h8,         32'hA000_0002, 1'b0, 1'b0));
        tbl.push_back(mk(2'b00, 32'h0,         1'b0, 1'b0, 32'hBAD0_0004, 1'b1, 1'b1, 32'h8,         32'h8,         32'hA000_0002, 1'b0, 1'b0));
        tbl.push_back(mk(2'b00, 32'h0,         1'b0, 1'b0, 32'hBAD0_0005, 1'b1, 1'b1, 32'h8,         32'h8,         32'hA000_0002, 1'b0, 1'b0));
        tbl.push_back(mk(2'b00, 32'h0,         1'b0, 1'b1, 32'hA000_0006, 1'b1, 1'b1, 32'h8,         32'hC,         32'hA000_0006, 1'b1, 1'b0));
        tbl.push_back(mk(2'b01, 32'h100,       1'b0, 1'b1, 32'hA000_0007, 1'b1, 1'b0, 32'hC,         32'h100,       32'hA000_0007, 1'b1, 1'b0));
        tbl.push_back(mk(2'b01, 32'h103,       1'b0, 1'b1, 32'hA000_0008, 1'b1, 1'b0, 32'h100,       32'h100,       32'hA000_0008, 1'b1, 1'b0));
        tbl.push_back(mk(2'b10, 32'h10,        1'b0, 1'b1, 32'hA000_0009, 1'b1, 1'b0, 32'h100,       32'h10,        32'hA000_0009, 1'b1, 1'b0));
        tbl.push_back(mk(2'b00, 32'h0,         1'b0, 1'b0, 32'hBAD0_000A, 1'b1, 1'b0, 32'h10,        32'h10,        32'hA000_0009, 1'b0, 1'b0));
        tbl.push_back(mk(2'b10, 32'h200,       1'b0, 1'b0, 32'hBAD0_000B, 1'b1, 1'b1, 32'h10,        32'h10,        32'hA000_0009, 1'b0, 1'b0));
        tbl.push_back(mk(2'b00, 32'h0,         1'b0, 1'b1, 32'hBAD0_000C, 1'b1, 1'b1, 32'h10,        32'h200,       32'hA000_0009, 1'b0, 1'b0));
        tbl.push_back(mk(2'b00, 32'h0,         1'b0, 1'b1, 32'hA000_000D, 1'b1, 1'b0, 32'h200,       32'h204,       32'hA000_000D, 1'b1, 1'b0));
        tbl.push_back(mk(2'b10, 32'h20,        1'b0, 1'b1, 32'hA000_000E, 1'b1, 1'b0, 32'h204,       32'h20,        32'hA000_000E, 1'b1, 1'b0));
        tbl.push_back(mk(2'b10, 32'h300,       1'b1, 1'b1, 32'hBAD0_000F, 1'b0, 1'b0, 32'h20,        32'h20,        32'hA000_000E, 1'b1, 1'b0));
        tbl.push_back(mk(2'b10, 32'h300,       1'b1, 1'b1, 32'hBAD0_0010, 1'b0, 1'b0, 32'h20,        32'h20,        32'hA000_000E, 1'b1, 1'b0));
        tbl.push_back(mk(2'b00, 32'h0,         1'b0, 1'b1, 32'hA000_0011, 1'b1, 1'b0, 32'h20,        32'h24,        32'hA000_0011, 1'b1, 1'b0));
        tbl.push_back(mk(2'b00, 32'h0,         1'b0, 1'b0, 32'hBAD0_0012, 1'b1, 1'b0, 32'h24,        32'h24,        32'hA000_0011, 1'b0, 1'b0));
        tbl.push_back(mk(2'b00, 32'h0,         1'b1, 1'b1, 32'hA000_0013, 1'b1, 1'b1, 32'h24,        32'h28,        32'hA000_0013, 1'b1, 1'b0));
        tbl.push_back(mk(2'b10, 32'hFFFF_FFFE, 1'b0, 1'b1, 32'hA000_0014, 1'b1, 1'b0, 32'h28,        32'hFFFF_FFFC, 32'hA000_0014, 1'b1, 1'b0));
        tbl.push_back(mk(2'b11, 32'h0,         1'b0, 1'b1, 32'hA000_0015, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'hA000_0015, 1'b1, 1'b0));

        // Reset state, asynchronous, before any clock edge.
        #2;
        chk("rst_pcf", PCF, 32'h0);
        chk("rst_instrf", InstrF, 32'h0);
        chk("rst_vld", InstrValidF, 1'b0);
        chk("rst_req", imem.IMemReq, 1'b0);
        chk("rst_stall", FetchStallF, 1'b0);
        chk("rst_err", FetchErr, 1'b0);
        @(posedge CLK);
        #1 RST = 1'b0;

        foreach (tbl[i]) step(tbl[i]);

        // Timeout boundary: 15 low cycles stays clean, 16 sets the sticky error.
        run_wait(15, 32'h0, 32'hA000_0015, 32'hC000_0000, 1'b0);
        run_wait(16, 32'h4, 32'hC000_0000, 32'hC000_0001, 1'b1);
        step(mk(2'b00, 32'h0, 1'b0, 1'b1, 32'hC000_0002, 1'b1, 1'b0, 32'h8, 32'hC, 32'hC000_0002, 1'b1, 1'b1));

        // Reset pulse in the middle of a wait abandons the request.
        step(mk(2'b00, 32'h0, 1'b0, 1'b0, 32'hBAD0_0020, 1'b1, 1'b0, 32'hC, 32'hC, 32'hC000_0002, 1'b0, 1'b1));
        step(mk(2'b00, 32'h0, 1'b0, 1'b0, 32'hBAD0_0021, 1'b1, 1'b1, 32'hC, 32'hC, 32'hC000_0002, 1'b0, 1'b1));
        @(negedge CLK);
        imem.IMemReady = 1'b1;  imem.IMemRData = 32'hEEEE_EEEE;
        PCSrcD = 2'b10;  PCJump = 32'h400;
        #2 RST = 1'b1;
        #1;
        chk("mid_rst_pcf", PCF, 32'h0);
        chk("mid_rst_instrf", InstrF, 32'h0);
        chk("mid_rst_vld", InstrValidF, 1'b0);
        chk("mid_rst_req", imem.IMemReq, 1'b0);
        chk("mid_rst_addr", imem.IMemAddr, 32'h0);
        chk("mid_rst_stall", FetchStallF, 1'b0);
        chk("mid_rst_err", FetchErr, 1'b0);
        @(posedge CLK);
        #1;
        chk("held_rst_instrf", InstrF, 32'h0);
        chk("held_rst_pcf", PCF, 32'h0);
        RST = 1'b0;
        step(mk(2'b00, 32'h0, 1'b0, 1'b1, 32'hB000_0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,         1'b0, 1'b0));
        step(mk(2'b00, 32'h0, 1'b0, 1'b1, 32'hB000_0001, 1'b1, 1'b0, 32'h0, 32'h4, 32'hB000_0001, 1'b1, 1'b0));

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequential controller for the fetch stage: owns the PC register, selects the next PC from sequential, branch and jump sources, and runs the request/ready handshake with a variable-latency instruction memory port. It sits between the hazard unit and decode stage (StallF, PCSrcD, PCBranchD, PCJump) and the instruction memory. It delivers PCF, PCPlus4F, InstrF and a valid flag to the IF/ID register, and raises a stall request while memory is busy.

## Interface
- ADDR_WIDTH, 32, PC and memory address width
- INSTR_WIDTH, 32, instruction width
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset
- MAX_WAIT, 15, wait cycles tolerated on one request before FetchErr sets
- CLK  in  1  single clock, rising edge
- RST  in  1  asynchronous reset, active-high
- PCSrcD  in  2  next-PC select: 00 PC+4, 01 branch, 10 jump, 11 treated as 00
- PCBranchD  in  ADDR_WIDTH  branch target
- PCJump  in  ADDR_WIDTH  jump target
- StallF  in  1  hazard-unit freeze of fetch
- IMemReady  in  1  memory has valid data for the current request this cycle
- IMemRData  in  INSTR_WIDTH  instruction data, valid when IMemReady=1
- IMemReq  out  1  request strobe
- IMemAddr  out  ADDR_WIDTH  request address, equals PCF
- PCF  out  ADDR_WIDTH  current fetch PC (registered)
- PCPlus4F  out  ADDR_WIDTH  PCF+4, combinational
- InstrF  out  INSTR_WIDTH  last accepted instruction (registered)
- InstrValidF  out  1  InstrF is valid for the IF/ID register
- FetchStallF  out  1  memory wait in progress; hazard unit must stall upstream
- FetchErr  out  1  sticky: a request exceeded MAX_WAIT wait cycles

## Operation
- States: BOOT, FETCH, WAIT.
- BOOT: entered on reset. IMemReq=0. Moves to FETCH on the next edge.
- FETCH with StallF=1: IMemReq=0. PCF, InstrF and InstrValidF hold. PCSrcD is ignored.
- FETCH with StallF=0: IMemReq=1.
  - IMemReady=1: InstrF<=IMemRData, InstrValidF<=1, PCF<=next PC.
  - IMemReady=0: go to WAIT. InstrValidF<=0 and the wait counter is cleared.
- Next PC: PCSrcD 01 selects PCBranchD, 10 selects PCJump, otherwise PCPlus4F. Bits [1:0] of the target are forced to 0.
- WAIT: IMemReq=1 on the same address, FetchStallF=1. StallF is ignored because the request must complete. Wait counter increments each cycle.
- Redirect during WAIT: PCSrcD=01/10 latches the target into a pending register and sets redirect_pend. The last such redirect wins.
- On IMemReady=1 in WAIT, return to FETCH:
  - redirect_pend=0: same accept behaviour as FETCH.
  - redirect_pend=1: the fetched word is discarded (InstrValidF<=0), PCF<=pending target, redirect_pend cleared.
- Wait counter saturates at MAX_WAIT+1. Reaching MAX_WAIT+1 sets FetchErr, which only RST clears. Fetch keeps waiting.
- PCPlus4F wraps modulo 2^ADDR_WIDTH (0xFFFF_FFFC+4 = 0).

## Timing
- Reset values, asynchronous:
  - PCF=RESET_VECTOR, InstrF=0, InstrValidF=0.
  - IMemReq=0, FetchStallF=0, FetchErr=0.
  - state=BOOT, redirect_pend=0, wait counter=0.
- RST asserted mid-WAIT: the request is abandoned immediately. No instruction is captured.
- Zero-wait memory (IMemReady tied 1): first request at cycle 1 after reset release, InstrValidF=1 at cycle 2. One instruction per cycle afterwards. Branch redirect costs no extra cycle beyond the one already fetched.
- Latency: instruction appears on InstrF one edge after the cycle with IMemReq=1 and IMemReady=1.
- FetchStallF is combinational from state (high exactly while in WAIT).
- IMemReady while IMemReq=0 is ignored.
- StallF=1 and redirect in the same FETCH cycle: the redirect is dropped. The hazard unit guarantees the redirect is re-presented.

## Test plan
- Reset release, IMemReady=1, PCSrcD=00: IMemAddr sequence 0x0,0x4,0x8. InstrF follows IMemRData one cycle later. InstrValidF rises at cycle 2.
- PCSrcD=01, PCBranchD=0x100 in a FETCH cycle: next PCF=0x100, PCPlus4F=0x104. PCBranchD=0x103 gives PCF=0x100.
- IMemReady low for 3 cycles at PCF=0x8: FetchStallF=1 for 3 cycles and IMemAddr stable at 0x8. InstrValidF=0 during the wait, then InstrF captured and PCF=0xC.
- Jump to 0x200 while in WAIT at 0x10: on completion InstrValidF=0, PCF=0x200, and the next accepted instruction comes from 0x200.
- StallF=1 for 2 cycles at PCF=0x20 with PCSrcD=10: IMemReq=0, PCF and InstrF held, jump ignored, then fetch resumes at 0x20.
- IMemReady held low for 16 cycles with MAX_WAIT=15: FetchErr sets and stays set after completion. An RST pulse mid-wait clears all outputs to reset values.
